s3_skid_register: RTL
=====================

Name: s3_skid_register

Overview:
- Parametrised successor of the execute-to-writeback (S3) pipeline register.
- Carries the ALU result, destination register select and write enable from execute to writeback.
- Adds a valid/ready handshake, a 2-entry skid buffer for full-throughput backpressure, synchronous flush, and optional suppression of writes to register 0.
- Sits between the ALU output and the register-file write port.

Parameters:
DATA_W, 32, width of the result field
SEL_W, 5, width of the destination register select
ZERO_REG_SUPPRESS, 1, when 1 a write to select 0 is captured with write enable forced to 0

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
flush  input  1  synchronous flush, discards all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  block can accept an entry this cycle
ALU_Result  input  DATA_W  result from execute
S2_WriteSelect  input  SEL_W  destination register from S2
S2_WriteEnable  input  1  write request from S2
out_valid  output  1  S3 entry valid
out_ready  input  1  writeback consumes entry this cycle
S3_Result  output  DATA_W  held result
S3_WriteSelect  output  SEL_W  held destination
S3_WriteEnable  output  1  register-file write strobe; already gated by out_valid
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Reset (rst=0, asynchronous):
  - Main and skid slots cleared; data fields 0; out_valid=0; S3_WriteEnable=0; occupancy=0.
  - in_ready=0 while rst=0, and 1 from the first clock after release.
- Storage:
  - Main slot drives the outputs.
  - Skid slot holds one extra entry. Its content is never visible on the outputs until it moves to main.
- Handshake:
  - Accept when in_valid & in_ready at a clk edge.
  - Consume when out_valid & out_ready at a clk edge.
  - in_ready = !skid_valid. It is registered and depends only on state, with no combinational path from out_ready.
- Next-state per edge (flush=0):
  - main empty, accept: input goes to main. Data visible next cycle; latency 1 clock.
  - main full, consume, skid empty: accept → input goes to main; no accept → main empties.
  - main full, consume, skid full: skid moves to main; skid empties. in_ready was 0, so there is no accept.
  - main full, no consume, accept: input goes to skid; in_ready drops next cycle.
  - main full, no consume, no accept: hold.
- Throughput: 1 entry/clock sustained when out_ready stays high.
- Flush:
  - flush=1 at an edge clears both valid bits; occupancy=0 next cycle.
  - A same-cycle accept is discarded.
  - A same-cycle consume still counts as delivered; writeback may act on it.
  - Data fields hold their stale values.
  - flush has priority over all other next-state rules.
- Write-enable rules:
  - Stored WE = S2_WriteEnable & !(ZERO_REG_SUPPRESS && S2_WriteSelect==0), computed at capture.
  - S3_WriteEnable = out_valid & stored WE. It is never 1 while out_valid=0.
- Data fields load only on a slot load. The outputs remain stable while out_valid=1 and out_ready=0.
- occupancy = main_valid + skid_valid.
- Reset during operation drops all entries immediately, without waiting for clk.
- in_valid=1 while in_ready=0 is legal. Nothing is captured; upstream must hold the entry.

Test Plan:
- Release reset, in_valid=1 with ALU_Result=0xDEADBEEF, sel=7, WE=1, out_ready=1 → next cycle out_valid=1, S3_Result=0xDEADBEEF, S3_WriteSelect=7, S3_WriteEnable=1, occupancy=1.
- Stream 0x1,0x2,0x3,… with out_ready=1 for 8 clocks → one output per clock, in order, in_ready constantly 1.
- Send A, then B with out_ready=0 → occupancy=2, in_ready=0, outputs hold A. Raise out_ready → A, then B on consecutive clocks; in_ready=1 one cycle after skid drains.
- sel=0, WE=1, ZERO_REG_SUPPRESS=1 → out_valid=1, S3_WriteEnable=0. Same stimulus with parameter 0 → S3_WriteEnable=1.
- occupancy=2, assert flush with in_valid=1 (value C) → next cycle out_valid=0, occupancy=0, C never appears.
- Pull rst low asynchronously mid-stream between clk edges (occupancy=2) → out_valid, S3_WriteEnable, occupancy go 0 immediately; S3_Result=0.

Source files
------------

// File: rtl/s3_skid_register.sv
// Execute-to-writeback (S3) pipeline register with valid/ready handshake and a
// 2-entry skid buffer, synchronous flush and optional register-0 write suppression.
module s3_skid_register #(
  parameter int DATA_W            = 32,
  parameter int SEL_W             = 5,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [SEL_W-1:0]  S2_WriteSelect,
  input  logic              S2_WriteEnable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] S3_Result,
  output logic [SEL_W-1:0]  S3_WriteSelect,
  output logic              S3_WriteEnable,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0]  main_sel_q, main_sel_d;
  logic              main_we_q, main_we_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0]  skid_sel_q, skid_sel_d;
  logic              skid_we_q, skid_we_d;
  logic              in_ready_q, in_ready_d;

  logic accept;
  logic consume;
  logic cap_we;

  assign accept  = in_valid & in_ready_q;
  assign consume = main_valid_q & out_ready;
  // Write enable is resolved once at capture so the slots only carry the final strobe.
  assign cap_we  = S2_WriteEnable &
                   !((ZERO_REG_SUPPRESS != 0) && (S2_WriteSelect == '0));

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    main_we_d    = main_we_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_we_d    = skid_we_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = ALU_Result;
        main_sel_d   = S2_WriteSelect;
        main_we_d    = cap_we;
      end
    end else if (consume) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_sel_d   = skid_sel_q;
        main_we_d    = skid_we_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = ALU_Result;
        main_sel_d   = S2_WriteSelect;
        main_we_d    = cap_we;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ALU_Result;
      skid_sel_d   = S2_WriteSelect;
      skid_we_d    = cap_we;
    end

    // Registered ready: a full skid slot is the only reason to stall upstream.
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_sel_q   <= '0;
      main_we_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_we_q    <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      main_we_q    <= main_we_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_we_q    <= skid_we_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = main_valid_q;
  assign S3_Result      = main_data_q;
  assign S3_WriteSelect = main_sel_q;
  assign S3_WriteEnable = main_valid_q & main_we_q;
  assign occupancy      = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
